// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared definitions for the ID/EX hazard stage.
// Contents:
//   NOP_INST           canonical bubble instruction, addi x0,x0,0
//   REG_ADDR_WIDTH     architectural register index width
//   CPU_WIDTH          datapath / pc width of the RV64 core
//   CTRL_BUNDLE_WIDTH  width of the decoded control bundle
//   state_e            bubble sequencer states (ST_RUN, ST_STALL)
package id_ex_hazard_stage_pkg;

   localparam logic [31:0] NOP_INST          = 32'h0000_0013;
   localparam int          REG_ADDR_WIDTH    = 5;
   localparam int          CPU_WIDTH         = 64;
   localparam int          CTRL_BUNDLE_WIDTH = 32;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_e;

endpackage

// File: rtl/id_ex_hazard_stage_bubble_fsm.sv
// Bubble sequencer for the ID/EX stage. It decides, each cycle, whether EX
// takes a bubble, whether PC and IF/ID must be frozen, and it counts the
// bubble cycles that hazards cost.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid_i        ID holds a real instruction
//   rest_from_id_i    RAW hazard detected in ID
//   rest_id_mem_i     hazard producer is in MEM (needs the longer sequence)
//   ex_flush_i        EX redirect, kills ID contents
//   mem_busy_i        LSU not ready, whole pipe frozen
//   id_stall_o        freeze PC and IF/ID (combinational)
//   bubble_sel_o      load a bubble into EX on this edge
//   stall_cycles_o    saturating count of bubble cycles inserted
module id_ex_hazard_stage_bubble_fsm
   import id_ex_hazard_stage_pkg::*;
#(
   parameter int EX_BUBBLES  = 1,
   parameter int MEM_BUBBLES = 2,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 id_valid_i,
   input  logic                 rest_from_id_i,
   input  logic                 rest_id_mem_i,
   input  logic                 ex_flush_i,
   input  logic                 mem_busy_i,
   output logic                 id_stall_o,
   output logic                 bubble_sel_o,
   output logic [CNT_WIDTH-1:0] stall_cycles_o
);

   localparam int CW = $clog2(MEM_BUBBLES + 1);
   // Bubbles still owed after the first one of a sequence.
   localparam logic [CW-1:0] EX_REM  = CW'(EX_BUBBLES - 1);
   localparam logic [CW-1:0] MEM_REM = CW'(MEM_BUBBLES - 1);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]  perf_q, perf_d;
   logic                  stall;
   logic                  count_bubble;
   logic [CW-1:0]         rem;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         perf_q  <= perf_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // skipped an assignment would otherwise infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      stall        = 1'b0;
      bubble_sel_o = 1'b0;
      count_bubble = 1'b0;
      rem          = rest_id_mem_i ? MEM_REM : EX_REM;

      if (mem_busy_i) begin
         // Whole pipe frozen; a pending flush is re-presented by upstream.
         stall = 1'b1;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (ex_flush_i) begin
                  bubble_sel_o = 1'b1;
               end else if (id_valid_i && rest_from_id_i) begin
                  bubble_sel_o = 1'b1;
                  stall        = 1'b1;
                  count_bubble = 1'b1;
                  if (rem != '0) begin
                     cnt_d   = rem;
                     state_d = ST_STALL;
                  end
               end
            end
            ST_STALL: begin
               bubble_sel_o = 1'b1;
               if (ex_flush_i) begin
                  cnt_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  stall        = 1'b1;
                  count_bubble = 1'b1;
                  cnt_d        = cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end

      perf_d = (count_bubble && (perf_q != '1)) ? perf_q + CNT_WIDTH'(1) : perf_q;
   end

   // Freeze request is forced low while reset is held.
   assign id_stall_o     = stall & rst_n;
   assign stall_cycles_o = perf_q;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with hazard bubble injection, EX-redirect flush
// and memory-busy freeze. The bubble sequencer lives in a sub-module; this
// file holds the EX-side pipeline register.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   id_valid_i, id_pc_i, id_inst_i,
//   id_reg_waddr_i, id_ctrl_i           ID-stage instruction and control
//   rest_from_id_i, rest_id_mem_i       hazard flags from the ID detector
//   ex_flush_i                          EX redirect
//   mem_busy_i                          LSU not ready
//   id_stall_o                          freeze PC and IF/ID
//   ex_valid_o, ex_pc_o, ex_inst_o,
//   ex_reg_waddr_o, ex_ctrl_o           registered EX-stage bundle
//   stall_cycles_o                      saturating bubble-cycle counter
module id_ex_hazard_stage
   import id_ex_hazard_stage_pkg::*;
#(
   parameter int PC_WIDTH    = CPU_WIDTH,
   parameter int CTRL_WIDTH  = CTRL_BUNDLE_WIDTH,
   parameter int EX_BUBBLES  = 1,
   parameter int MEM_BUBBLES = 2,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid_i,
   input  logic [PC_WIDTH-1:0]       id_pc_i,
   input  logic [31:0]               id_inst_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_reg_waddr_i,
   input  logic [CTRL_WIDTH-1:0]     id_ctrl_i,
   input  logic                      rest_from_id_i,
   input  logic                      rest_id_mem_i,
   input  logic                      ex_flush_i,
   input  logic                      mem_busy_i,
   output logic                      id_stall_o,
   output logic                      ex_valid_o,
   output logic [PC_WIDTH-1:0]       ex_pc_o,
   output logic [31:0]               ex_inst_o,
   output logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr_o,
   output logic [CTRL_WIDTH-1:0]     ex_ctrl_o,
   output logic [CNT_WIDTH-1:0]      stall_cycles_o
);

   logic                      bubble_sel;
   logic                      ex_valid_q;
   logic [PC_WIDTH-1:0]       ex_pc_q;
   logic [31:0]               ex_inst_q;
   logic [REG_ADDR_WIDTH-1:0] ex_reg_waddr_q;
   logic [CTRL_WIDTH-1:0]     ex_ctrl_q;

   id_ex_hazard_stage_bubble_fsm #(
      .EX_BUBBLES  (EX_BUBBLES),
      .MEM_BUBBLES (MEM_BUBBLES),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_fsm (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid_i     (id_valid_i),
      .rest_from_id_i (rest_from_id_i),
      .rest_id_mem_i  (rest_id_mem_i),
      .ex_flush_i     (ex_flush_i),
      .mem_busy_i     (mem_busy_i),
      .id_stall_o     (id_stall_o),
      .bubble_sel_o   (bubble_sel),
      .stall_cycles_o (stall_cycles_o)
   );

   // Reset value and bubble are the same canonical NOP slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q     <= 1'b0;
         ex_pc_q        <= '0;
         ex_inst_q      <= NOP_INST;
         ex_reg_waddr_q <= '0;
         ex_ctrl_q      <= '0;
      end else if (mem_busy_i) begin
         ex_valid_q     <= ex_valid_q;
      end else if (bubble_sel) begin
         ex_valid_q     <= 1'b0;
         ex_pc_q        <= '0;
         ex_inst_q      <= NOP_INST;
         ex_reg_waddr_q <= '0;
         ex_ctrl_q      <= '0;
      end else begin
         ex_valid_q     <= id_valid_i;
         ex_pc_q        <= id_pc_i;
         ex_inst_q      <= id_inst_i;
         ex_reg_waddr_q <= id_reg_waddr_i;
         ex_ctrl_q      <= id_ctrl_i;
      end
   end

   assign ex_valid_o     = ex_valid_q;
   assign ex_pc_o        = ex_pc_q;
   assign ex_inst_o      = ex_inst_q;
   assign ex_reg_waddr_o = ex_reg_waddr_q;
   assign ex_ctrl_o      = ex_ctrl_q;

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register with load-use/RAW stall sequencing for the RV64 core. Consumes the combinational hazard flags from the ID-stage hazard detector (rest_from_id, rest_id_mem). On a hazard it freezes PC and IF/ID, and injects a fixed number of NOP bubbles into EX. Also handles EX-redirect flush and a global memory-busy freeze, and keeps a stall-cycle performance counter.

Parameters:
PC_WIDTH, 64, width of pc fields
CTRL_WIDTH, 32, width of the decoded control bundle passed to EX
EX_BUBBLES, 1, bubbles inserted for a hazard on an EX-stage producer (rest_id_mem=0); must be >=1
MEM_BUBBLES, 2, bubbles inserted when rest_id_mem=1; must be >=EX_BUBBLES
CNT_WIDTH, 32, width of the stall_cycles perf counter

Ports:
clk  input  1  core clock
rst_n  input  1  reset: one clock; reset is asynchronous and active-low
id_valid  input  1  ID holds a real instruction
id_pc  input  PC_WIDTH  ID instruction pc
id_inst  input  32  ID instruction word
id_reg_waddr  input  5  ID destination register
id_ctrl  input  CTRL_WIDTH  decoded control bundle
rest_from_id  input  1  RAW hazard detected in ID
rest_id_mem  input  1  hazard needs MEM-stage data (qualifies rest_from_id)
ex_flush  input  1  EX redirect (branch/jump taken); kills ID contents
mem_busy  input  1  LSU not ready; freeze whole pipe
id_stall  output  1  freeze PC and IF/ID (combinational)
ex_valid  output  1  EX slot holds a real instruction
ex_pc  output  PC_WIDTH  registered pc to EX
ex_inst  output  32  registered instruction to EX
ex_reg_waddr  output  5  registered rd to EX
ex_ctrl  output  CTRL_WIDTH  registered control to EX
stall_cycles  output  CNT_WIDTH  count of bubble cycles inserted, saturating

Behaviour:
- Reset (rst_n low, async): state=RUN, cnt=0, ex_valid=0, ex_pc=0, ex_inst=32'h0000_0013, ex_reg_waddr=0, ex_ctrl=0, stall_cycles=0. id_stall=0 while in reset.
- Bubble = ex_valid 0, ex_pc 0, ex_inst 32'h0000_0013 (addi x0,x0,0), ex_reg_waddr 0, ex_ctrl 0.
- Counter cnt width = clog2(MEM_BUBBLES+1); holds bubbles remaining after the current one.
- Priority per cycle: mem_busy > ex_flush > hazard > advance.
- mem_busy=1 (any state): all EX regs, state, cnt, stall_cycles hold; id_stall=1. ex_flush is ignored that cycle; upstream holds ex_flush until mem_busy drops.
- State RUN:
  - ex_flush: EX<=bubble; id_stall=0; stay RUN.
  - id_valid & rest_from_id: EX<=bubble; id_stall=1; stall_cycles+=1.
    - n = rest_id_mem ? MEM_BUBBLES : EX_BUBBLES.
    - n==1 -> stay RUN; else cnt<=n-1, go STALL.
  - rest_from_id with id_valid=0: ignored; normal advance.
  - Otherwise advance: ex_valid<=id_valid; ex_pc/inst/reg_waddr/ctrl<=id_*; id_stall=0.
- State STALL:
  - rest_* ignored.
  - ex_flush: EX<=bubble; cnt<=0; go RUN; id_stall=0.
  - Else: EX<=bubble; id_stall=1; stall_cycles+=1; cnt<=cnt-1; go RUN when cnt==1.
- One-cycle latency: ID fields appear on ex_* the cycle after a non-stalled, non-busy edge.
- stall_cycles saturates at all-ones and does not wrap.
- Back-to-back hazards: on return to RUN the hazard detector re-evaluates against the new EX/MEM contents. A new hazard starts a new sequence immediately, with no idle gap.

Decomposition:
- Shared package (rvseed defines): NOP_INST=32'h0000_0013, REG_ADDR_WIDTH=5, CPU_WIDTH, ctrl-bundle width constant, state encodings ST_RUN/ST_STALL.
- One natural sub-module: hazard_bubble_fsm (state, cnt, id_stall, bubble_sel, perf count). The pipeline register stays in the top.

Test Plan:
- Normal flow: id_valid=1, id_pc=0x8000_0004, id_inst=0x00B50533, no hazard -> next cycle ex_valid=1, ex_pc=0x8000_0004, ex_inst=0x00B50533; id_stall=0 throughout.
- EX hazard: rest_from_id=1, rest_id_mem=0 for one cycle -> id_stall=1 that cycle; next EX = bubble (ex_inst=0x13, ex_valid=0); state stays RUN; stall_cycles=1.
- MEM hazard: rest_from_id=1, rest_id_mem=1 -> id_stall=1 for 2 consecutive cycles; 2 bubbles in EX; then the held ID instruction enters EX; stall_cycles=2.
- Flush mid-stall: MEM hazard, then ex_flush=1 in the STALL cycle -> EX bubble, state RUN, id_stall=0 that cycle; stall_cycles=1.
- mem_busy during STALL: assert mem_busy 3 cycles while cnt=1 -> ex_* frozen, id_stall=1, stall_cycles unchanged; after release, one more bubble, then RUN.
- Async reset mid-STALL: drop rst_n between clock edges -> outputs reset immediately (ex_valid=0, ex_inst=0x13, stall_cycles=0); after release, normal advance resumes in RUN.
